// File: rtl/tlul_host_arbiter.sv
// Round-robin arbiter sharing one TL-UL host port among NUM_REQ requesters, one outstanding transaction.
// Optional D-channel timeout enabled by defining TLUL_ARB_TIMEOUT_EN.
module tlul_host_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SRC_W   = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [3*NUM_REQ-1:0]       req_opcode,
  input  logic [ADDR_W*NUM_REQ-1:0]  req_addr,
  input  logic [DATA_W*NUM_REQ-1:0]  req_data,
  input  logic [(DATA_W/8)*NUM_REQ-1:0] req_mask,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_error,
  output logic                       a_valid,
  input  logic                       a_ready,
  output logic [2:0]                 a_opcode,
  output logic [2:0]                 a_size,
  output logic [SRC_W-1:0]           a_source,
  output logic [ADDR_W-1:0]          a_address,
  output logic [DATA_W/8-1:0]        a_mask,
  output logic [DATA_W-1:0]          a_data,
  input  logic                       d_valid,
  output logic                       d_ready,
  input  logic [2:0]                 d_opcode,
  input  logic [SRC_W-1:0]           d_source,
  input  logic [DATA_W-1:0]          d_data,
  input  logic                       d_error,
  output logic                       busy,
  output logic                       unexp_rsp
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MASK_W = DATA_W / 8;
  localparam logic [2:0]     A_SIZE    = 3'($clog2(DATA_W / 8));
  localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_D = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [IDX_W-1:0]   rr_ptr_reg;
  logic [IDX_W-1:0]   grant_reg;
  logic [2:0]         a_opcode_reg;
  logic [2:0]         a_size_reg;
  logic [ADDR_W-1:0]  a_address_reg;
  logic [DATA_W-1:0]  a_data_reg;
  logic [MASK_W-1:0]  a_mask_reg;
  logic [NUM_REQ-1:0] rsp_valid_reg;
  logic [DATA_W-1:0]  rsp_data_reg;
  logic               rsp_error_reg;
  logic               unexp_rsp_reg;

  // Per-requester views of the flattened request buses.
  logic [2:0]        op_arr   [NUM_REQ];
  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [DATA_W-1:0] data_arr [NUM_REQ];
  logic [MASK_W-1:0] mask_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign op_arr[gi]   = req_opcode[3*gi +: 3];
    assign addr_arr[gi] = req_addr[ADDR_W*gi +: ADDR_W];
    assign data_arr[gi] = req_data[DATA_W*gi +: DATA_W];
    assign mask_arr[gi] = req_mask[MASK_W*gi +: MASK_W];
  end

  // Rotate the valid vector so rr_ptr sits at bit 0, then take the lowest set bit.
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [IDX_W-1:0]     win_off;
  logic [IDX_W:0]       win_sum;
  logic [IDX_W-1:0]     winner;

  always_comb begin
    req_dbl = {req_valid, req_valid} >> rr_ptr_reg;
    req_rot = req_dbl[NUM_REQ-1:0];
    win_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) win_off = IDX_W'(k);
    end
    win_sum = {1'b0, rr_ptr_reg} + {1'b0, win_off};
    if (win_sum >= NUM_REQ_W) win_sum = win_sum - NUM_REQ_W;
    winner = win_sum[IDX_W-1:0];
  end

  logic [IDX_W:0] rr_sum;
  logic [IDX_W-1:0] rr_inc;

  always_comb begin
    rr_sum = {1'b0, grant_reg} + {{IDX_W{1'b0}}, 1'b1};
    if (rr_sum >= NUM_REQ_W) rr_sum = '0;
    rr_inc = rr_sum[IDX_W-1:0];
  end

  // No new grant while the previous response strobe is still on the wire.
  logic grant_fire;
  logic beat_match;
  logic timeout_hit;
  logic [NUM_REQ-1:0] grant_ohot;

  assign grant_fire = (state_reg == IDLE) && (rsp_valid_reg == '0) && (req_valid != '0);
  assign beat_match = d_valid && (state_reg == WAIT_D) && (d_source == SRC_W'(grant_reg));
  assign grant_ohot = NUM_REQ'(1) << grant_reg;

`ifdef TLUL_ARB_TIMEOUT_EN
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] wait_cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == ISSUE) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == WAIT_D && !beat_match) begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end

  // Fires on the cycle whose missing beat would bring the count to TIMEOUT.
  assign timeout_hit = (state_reg == WAIT_D) && !beat_match && (wait_cnt_reg == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_fire) state_next = ISSUE;
      ISSUE:   if (a_ready) state_next = WAIT_D;
      WAIT_D:  if (beat_match || timeout_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_reg    <= '0;
      grant_reg     <= '0;
      a_opcode_reg  <= '0;
      a_size_reg    <= '0;
      a_address_reg <= '0;
      a_data_reg    <= '0;
      a_mask_reg    <= '0;
      rsp_valid_reg <= '0;
      rsp_data_reg  <= '0;
      rsp_error_reg <= 1'b0;
      unexp_rsp_reg <= 1'b0;
    end else begin
      rsp_valid_reg <= '0;
      if (grant_fire) begin
        grant_reg     <= winner;
        a_opcode_reg  <= op_arr[winner];
        a_size_reg    <= A_SIZE;
        a_address_reg <= addr_arr[winner];
        a_data_reg    <= data_arr[winner];
        a_mask_reg    <= mask_arr[winner];
      end
      if (beat_match) begin
        rsp_valid_reg <= grant_ohot;
        rsp_data_reg  <= d_data;
        rsp_error_reg <= d_error;
        rr_ptr_reg    <= rr_inc;
      end else if (timeout_hit) begin
        rsp_valid_reg <= grant_ohot;
        rsp_data_reg  <= '0;
        rsp_error_reg <= 1'b1;
        rr_ptr_reg    <= rr_inc;
      end
      if (d_valid && !beat_match) unexp_rsp_reg <= 1'b1;
    end
  end

  // Gated by reset_n so req_ready stays low while reset is held.
  assign req_ready = (grant_fire && reset_n) ? (NUM_REQ'(1) << winner) : '0;

  assign a_valid   = (state_reg == ISSUE);
  assign a_opcode  = a_opcode_reg;
  assign a_size    = a_size_reg;
  assign a_source  = SRC_W'(grant_reg);
  assign a_address = a_address_reg;
  assign a_mask    = a_mask_reg;
  assign a_data    = a_data_reg;
  assign d_ready   = (state_reg == WAIT_D);
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_error = rsp_error_reg;
  assign busy      = (state_reg != IDLE);
  assign unexp_rsp = unexp_rsp_reg;

  // d_opcode is deliberately ignored; TIMEOUT only matters with the timeout build.
  logic unused_ok;
  assign unused_ok = ^{d_opcode, (TIMEOUT != 0)};

endmodule

// File: tb/tb_tlul_host_arbiter.sv
// Directed bench for tlul_host_arbiter: bench acts as TL-UL device, scoreboard queue holds expected responses.
module tb_tlul_host_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 3;
  localparam int MW = DW / 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [3*N-1:0]  req_opcode = '0;
  logic [AW*N-1:0] req_addr = '0;
  logic [DW*N-1:0] req_data = '0;
  logic [MW*N-1:0] req_mask = '0;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            rsp_error;
  logic            a_valid;
  logic            a_ready = 1'b0;
  logic [2:0]      a_opcode;
  logic [2:0]      a_size;
  logic [SW-1:0]   a_source;
  logic [AW-1:0]   a_address;
  logic [MW-1:0]   a_mask;
  logic [DW-1:0]   a_data;
  logic            d_valid = 1'b0;
  logic            d_ready;
  logic [2:0]      d_opcode = '0;
  logic [SW-1:0]   d_source = '0;
  logic [DW-1:0]   d_data = '0;
  logic            d_error = 1'b0;
  logic            busy;
  logic            unexp_rsp;

  tlul_host_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .SRC_W(SW), .TIMEOUT(10)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
    .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_source(d_source),
    .d_data(d_data), .d_error(d_error), .busy(busy), .unexp_rsp(unexp_rsp)
  );

  typedef struct {
    int          idx;
    logic [DW-1:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_err = 0;

  logic [2:0]    op_m   [N];
  logic [AW-1:0] addr_m [N];
  logic [DW-1:0] data_m [N];
  logic [MW-1:0] mask_m [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [MW-1:0] mask);
    op_m[i] = op; addr_m[i] = addr; data_m[i] = data; mask_m[i] = mask;
    req_opcode[3*i +: 3] = op;
    req_addr[AW*i +: AW] = addr;
    req_data[DW*i +: DW] = data;
    req_mask[MW*i +: MW] = mask;
  endtask

  // Called in the cycle the response strobe is expected.
  task automatic check_rsp();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      $display("rsp: req=%0d data=%h err=%0b rsp_valid=%b", e.idx, rsp_data, rsp_error, rsp_valid);
      chk("rsp_valid", 64'(rsp_valid), 64'(1) << e.idx);
      chk("rsp_data", 64'(rsp_data), 64'(e.data));
      chk("rsp_error", 64'(rsp_error), 64'(e.err));
      chk("no_grant_in_rsp", 64'(req_ready), 64'd0);
      chk("busy_rsp", 64'(busy), 64'd0);
      tick();
      chk("rsp_one_cycle", 64'(rsp_valid), 64'd0);
    end
  endtask

  // Full transaction from grant to response; bad_src >= 0 injects a stray D beat first.
  task automatic serve(input int g, input int a_delay, input int d_delay,
                       input logic [DW-1:0] rdata, input logic rerr,
                       input logic keep_valid, input int bad_src);
    int waited = 0;
    #1;
    while (req_ready == '0 && waited < 20) begin
      tick(); #1; waited++;
    end
    chk("grant_bound", 64'(waited < 20), 64'd1);
    $display("grant: req_ready=%b expected_req=%0d", req_ready, g);
    chk("req_ready", 64'(req_ready), 64'(1) << g);
    tick();
    if (!keep_valid) req_valid[g] = 1'b0;
    chk("a_valid", 64'(a_valid), 64'd1);
    chk("a_opcode", 64'(a_opcode), 64'(op_m[g]));
    chk("a_source", 64'(a_source), 64'(g));
    chk("a_size", 64'(a_size), 64'd2);
    chk("a_address", 64'(a_address), 64'(addr_m[g]));
    chk("a_data", 64'(a_data), 64'(data_m[g]));
    chk("a_mask", 64'(a_mask), 64'(mask_m[g]));
    chk("busy_issue", 64'(busy), 64'd1);
    for (int s = 0; s < a_delay; s++) begin
      tick();
      chk("a_valid_hold", 64'(a_valid), 64'd1);
      chk("a_address_hold", 64'(a_address), 64'(addr_m[g]));
      chk("a_data_hold", 64'(a_data), 64'(data_m[g]));
      chk("a_mask_hold", 64'(a_mask), 64'(mask_m[g]));
    end
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    chk("a_valid_drop", 64'(a_valid), 64'd0);
    chk("d_ready", 64'(d_ready), 64'd1);
    for (int s = 0; s < d_delay; s++) begin
      tick();
      chk("rsp_idle_wait", 64'(rsp_valid), 64'd0);
    end
    if (bad_src >= 0) begin
      d_valid = 1'b1; d_source = SW'(bad_src); d_data = 32'h0BAD_0BAD; d_error = 1'b0;
      tick();
      d_valid = 1'b0;
      chk("unexp_set", 64'(unexp_rsp), 64'd1);
      chk("no_rsp_bad_src", 64'(rsp_valid), 64'd0);
      chk("still_wait_d", 64'(d_ready), 64'd1);
    end
    d_valid = 1'b1; d_source = SW'(g); d_data = rdata; d_error = rerr;
    sb.push_back('{idx: g, data: rdata, err: rerr});
    tick();
    d_valid = 1'b0;
    check_rsp();
  endtask

  initial begin
    // Reset state, requests already pending must not be accepted
    req_valid = 4'b1111;
    #12;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_a_valid", 64'(a_valid), 64'd0);
    chk("rst_d_ready", 64'(d_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_unexp", 64'(unexp_rsp), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_a_address", 64'(a_address), 64'd0);
    for (int i = 0; i < N; i++)
      set_req(i, 3'd0, 32'h1000 + 32'(i) * 32'h10, 32'hA000_0000 + 32'(i), 4'hF);
    tick();
    reset_n = 1'b1;

    // Round robin with all requesters pending
    for (int k = 0; k < 5; k++)
      serve(k % N, 0, 0, 32'h5500_0000 + 32'(k), 1'b0, 1'b1, -1);
    req_valid = '0;

    // Single Get from requester 0
    set_req(0, 3'd4, 32'h100, 32'h0, 4'hF);
    req_valid[0] = 1'b1;
    serve(0, 0, 2, 32'hDEADBEEF, 1'b0, 1'b0, -1);

    // A channel stalled 5 cycles, partial PutPartialData with error response
    set_req(1, 3'd1, 32'h2222_0004, 32'h1234_5678, 4'b0011);
    req_valid[1] = 1'b1;
    serve(1, 5, 1, 32'h0000_00EE, 1'b1, 1'b0, -1);

    // Stray beat from source 1 while waiting for requester 2
    set_req(2, 3'd4, 32'h3000_0000, 32'h0, 4'hF);
    req_valid[2] = 1'b1;
    serve(2, 0, 0, 32'hCAFE_F00D, 1'b0, 1'b0, 1);
    tick();
    chk("unexp_sticky", 64'(unexp_rsp), 64'd1);

    // Asynchronous reset in WAIT_D
    set_req(3, 3'd4, 32'h4000_0000, 32'h0, 4'hF);
    req_valid[3] = 1'b1;
    #1;
    chk("grant_before_rst", 64'(req_ready), 64'b1000);
    tick();
    req_valid = '0;
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    chk("wait_d_before_rst", 64'(d_ready), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    $display("async reset: a_valid=%0b d_ready=%0b busy=%0b rsp_valid=%b", a_valid, d_ready, busy, rsp_valid);
    chk("arst_a_valid", 64'(a_valid), 64'd0);
    chk("arst_d_ready", 64'(d_ready), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("arst_unexp", 64'(unexp_rsp), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    req_valid = 4'b1111;
    serve(0, 0, 0, 32'h0F0F_0F0F, 1'b0, 1'b0, -1);
    req_valid = '0;

`ifdef TLUL_ARB_TIMEOUT_EN
    // No D beat: forced error response after TIMEOUT cycles in WAIT_D
    set_req(1, 3'd4, 32'h5000_0000, 32'h0, 4'hF);
    req_valid[1] = 1'b1;
    #1;
    chk("to_grant", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    sb.push_back('{idx: 1, data: '0, err: 1'b1});
    for (int c = 0; c < 10; c++) begin
      chk("to_early", 64'(rsp_valid), 64'd0);
      tick();
    end
    check_rsp();
    chk("to_busy", 64'(busy), 64'd0);
    d_valid = 1'b1; d_source = SW'(1); d_data = 32'h1; d_error = 1'b0;
    tick();
    d_valid = 1'b0;
    chk("to_late_unexp", 64'(unexp_rsp), 64'd1);
`endif

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tlul_host_arbiter.md
Name: tlul_host_arbiter

Overview:
- Shares one TL-UL host port (A/D channels) between NUM_REQ internal requesters, one outstanding transaction at a time.
- Round-robin grant. The granted request is registered onto channel A. The D response is routed back to the granted requester by a_source/d_source.
- Sits between requester logic and the tlulMaster-side TL-UL link.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width (32 or 64).
- SRC_W, 3, a_source/d_source width; must satisfy 2^SRC_W >= NUM_REQ.
- TIMEOUT, 255, cycles in WAIT_D before forced error response (feature only).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_opcode  in  3*NUM_REQ  TL-UL A opcode per requester, slice i = [3i+2:3i].
- req_addr  in  ADDR_W*NUM_REQ  address per requester.
- req_data  in  DATA_W*NUM_REQ  write data per requester.
- req_mask  in  (DATA_W/8)*NUM_REQ  byte mask per requester.
- rsp_valid  out  NUM_REQ  one-cycle response strobe.
- rsp_data  out  DATA_W  response data (shared, qualified by rsp_valid).
- rsp_error  out  1  response d_error (shared).
- a_valid/a_ready  out/in  1/1  channel A handshake.
- a_opcode, a_size, a_source, a_address, a_mask, a_data  out  3, 3, SRC_W, ADDR_W, DATA_W/8, DATA_W  channel A fields.
- d_valid/d_ready  in/out  1/1  channel D handshake.
- d_opcode, d_source, d_data, d_error  in  3, SRC_W, DATA_W, 1  channel D fields.
- busy  out  1  state != IDLE.
- unexp_rsp  out  1  sticky flag: D beat with wrong source or in wrong state; cleared only by reset.

Behaviour:
- Reset (async, immediate): state=IDLE, rr_ptr=0; all outputs 0 (req_ready, rsp_valid, a_valid, d_ready, busy, unexp_rsp, all A fields). An in-flight transaction is abandoned.
- FSM states: IDLE, ISSUE, WAIT_D.
- IDLE:
  - Winner = first i with req_valid[i] searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[winner]=1 combinationally, same cycle.
  - On that edge: capture opcode/addr/data/mask into A registers, a_source=winner, a_size=log2(DATA_W/8); state→ISSUE.
  - No req_valid: stay in IDLE.
- ISSUE:
  - a_valid=1; all A fields held stable.
  - On a_valid&&a_ready: a_valid=0 next cycle; state→WAIT_D.
- WAIT_D:
  - d_ready=1.
  - On d_valid with d_source==grant: next cycle rsp_valid[grant]=1 for exactly 1 cycle, rsp_data=d_data, rsp_error=d_error; rr_ptr=(grant+1) mod NUM_REQ; state→IDLE.
  - d_valid with other source: beat consumed and dropped, unexp_rsp←1, remain in WAIT_D.
- d_ready=0 outside WAIT_D. A d_valid seen in IDLE/ISSUE sets unexp_rsp.
- Earliest new grant is the IDLE cycle after rsp_valid. Minimum per-transaction period is 4 cycles with a_ready and d_valid immediate.
- Requesters hold req_valid and fields until req_ready. Dropping req_valid before grant is legal: no grant, no response.
- Requesters have no backpressure on rsp; rsp_valid must be taken when asserted.
- d_opcode is not checked. The AccessAck/AccessAckData distinction is the requester's concern.

Optional Feature:
- Macro: TLUL_ARB_TIMEOUT_EN.
- Defined:
  - An 8..16-bit wait counter clears on WAIT_D entry and increments each WAIT_D cycle without a matching beat.
  - When the count reaches TIMEOUT: rsp_valid[grant] pulses with rsp_error=1, rsp_data=0; state→IDLE; rr_ptr advances.
  - A late D beat afterwards sets unexp_rsp.
- Undefined: no counter; WAIT_D waits indefinitely.

Test Plan:
- Single requester 0 Get addr 0x100, a_ready=1, d_valid 2 cycles later with data 0xDEADBEEF source 0 -> a_opcode=4, a_source=0, a_size=2; rsp_valid[0] one cycle, rsp_data=0xDEADBEEF, rsp_error=0.
- req_valid=4'b1111 held continuously, immediate acks -> grant order 0,1,2,3,0; exactly one req_ready high per grant.
- a_ready low 5 cycles during ISSUE -> a_valid stays 1; a_address/a_data/a_mask unchanged all 5 cycles.
- WAIT_D for requester 2, inject d_valid with source 1, then source 2 -> unexp_rsp=1 and stays set; only rsp_valid[2] pulses.
- reset_n low asynchronously mid-WAIT_D -> a_valid, d_ready, busy, rsp_valid all 0 immediately; after release the next grant goes to requester 0.
- With TLUL_ARB_TIMEOUT_EN, TIMEOUT=10, no D beat -> rsp_valid[grant] with rsp_error=1 10 cycles after WAIT_D entry; busy=0 next cycle.
